// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//   Byte FIFO plus drain controller placed directly upstream of a UART
//   transmitter. Producers push bytes at any rate; the drain FSM hands them to
//   the transmitter one at a time over the sdata/tx_start/tx_busy handshake,
//   in strict arrival order.
//
// Parameters
//   DEPTH_LOG2  log2 of the FIFO depth (depth = 2**DEPTH_LOG2 bytes)
//
// Ports
//   clk       in   single clock, all logic on its rising edge
//   rstn      in   synchronous active-low reset
//   wdata     in   byte to enqueue, sampled when wr_en=1
//   wr_en     in   push request
//   full      out  count == depth
//   empty     out  count == 0
//   count     out  bytes currently stored (0..depth)
//   overflow  out  sticky: a push was dropped; cleared only by reset
//   sdata     out  byte presented to the transmitter (holds between transfers)
//   tx_start  out  one-cycle start pulse to the transmitter
//   tx_busy   in   transmitter busy, rises the cycle after tx_start
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [7:0]            wdata,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic [7:0]            sdata,
  output logic                  tx_start,
  input  logic                  tx_busy
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  localparam logic [DEPTH_LOG2:0]   CNT_DEPTH = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

  // Drain FSM encoding
  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WAIT_BUSY = 2'd1;
  localparam logic [1:0] S_WAIT_DONE = 2'd2;

  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_overflow;
  logic [1:0]            r_state;
  logic [7:0]            r_sdata;
  logic                  r_tx_start;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_pop;
  logic                  w_push;

  assign w_full  = (r_count == CNT_DEPTH);
  assign w_empty = (r_count == '0);

  // A pop happens exactly when the idle FSM finds data waiting.
  assign w_pop   = (r_state == S_IDLE) && !w_empty;

  // When full, a push is still accepted if a pop frees the slot on the same
  // edge: wr_ptr == rd_ptr then, and the read sees the old byte because both
  // updates are non-blocking.
  assign w_push  = wr_en && (!w_full || w_pop);

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  // NOTE: the byte array has no reset; its contents are only ever read
  // behind count, so clearing it would buy nothing.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Pointers, occupancy and overflow
  // ---------------------------------------------------------------------------
  // NOTE: all state is updated with non-blocking assignments so every
  // register sees the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end

      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_ONE;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CNT_ONE;
      end

      // A request that was not accepted is a dropped byte.
      if (wr_en && !w_push) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Drain FSM
  // ---------------------------------------------------------------------------
  // tx_start is raised only on the S_IDLE -> S_WAIT_BUSY transition and
  // cleared in S_WAIT_BUSY, so it can never be high two cycles in a row.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_sdata    <= 8'h00;
      r_tx_start <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx_start <= 1'b0;
          if (w_pop) begin
            r_sdata    <= r_mem[r_rd_ptr];
            r_tx_start <= 1'b1;
            r_state    <= S_WAIT_BUSY;
          end
        end

        S_WAIT_BUSY: begin
          r_tx_start <= 1'b0;
          if (tx_busy) begin
            r_state <= S_WAIT_DONE;
          end
        end

        S_WAIT_DONE: begin
          r_tx_start <= 1'b0;
          if (!tx_busy) begin
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_tx_start <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  assign full     = w_full;
  assign empty    = w_empty;
  assign count    = r_count;
  assign overflow = r_overflow;
  assign sdata    = r_sdata;
  assign tx_start = r_tx_start;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
//   Directed self-checking bench for uart_tx_fifo. Inputs change on the falling
//   clock edge, outputs are sampled on the falling edge. A transmitter model
//   answers tx_start either with a fixed-length busy window or with a real
//   8N1 serial frame (4 clocks per half bit); a decoder recovers the bytes.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

  logic       clk;
  logic       rstn;
  logic [7:0] wdata;
  logic       wr_en;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic [7:0] sdata;
  logic       tx_start;
  wire logic  tx_busy;

  // tx_busy is the OR of a manual override and the transmitter model.
  logic       busy_man;
  logic       busy_model;
  assign tx_busy = busy_man | busy_model;

  // 0: model silent, 1: fixed busy window, 2: serial transmitter
  int         tx_mode;
  int         busy_len;
  logic [7:0] tx_byte;
  logic       ser_line;
  logic [7:0] rx_byte;

  int         n_vec;
  int         n_err;
  int         start_cnt;
  int         dbl_cnt;
  int         base_cnt;
  logic       prev_start;

  logic [7:0] cap_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] v;

  uart_tx_fifo #(.DEPTH_LOG2(4)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .wdata    (wdata),
    .wr_en    (wr_en),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .sdata    (sdata),
    .tx_start (tx_start),
    .tx_busy  (tx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start pulse bookkeeping and capture of every byte handed over.
  initial begin
    start_cnt  = 0;
    dbl_cnt    = 0;
    prev_start = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start === 1'b1) begin
        start_cnt++;
        cap_q.push_back(sdata);
        if (prev_start) dbl_cnt++;
      end
      prev_start = (tx_start === 1'b1);
    end
  end

  // Transmitter model.
  initial begin
    busy_model = 1'b0;
    ser_line   = 1'b1;
    forever begin
      @(negedge clk);
      if (tx_start === 1'b1 && tx_mode != 0) begin
        tx_byte = sdata;
        @(posedge clk); #1;
        busy_model = 1'b1;
        if (tx_mode == 2) begin
          ser_line = 1'b0;
          for (int i = 0; i < 8; i++) begin
            repeat (8) @(posedge clk);
            #1 ser_line = tx_byte[i];
          end
          repeat (8) @(posedge clk);
          #1 ser_line = 1'b1;
          repeat (8) @(posedge clk);
          #1;
        end else begin
          repeat (busy_len) @(posedge clk);
          #1;
        end
        busy_model = 1'b0;
      end
    end
  end

  // Serial decoder: samples mid-bit, 8 clocks per bit.
  initial begin
    forever begin
      @(negedge ser_line);
      repeat (4) @(posedge clk);
      if (ser_line == 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (8) @(posedge clk);
          rx_byte[i] = ser_line;
        end
        repeat (8) @(posedge clk);
        rx_q.push_back(rx_byte);
      end
    end
  end

  initial begin
    n_vec    = 0;
    n_err    = 0;
    rstn     = 1'b0;
    wr_en    = 1'b0;
    wdata    = 8'h00;
    busy_man = 1'b0;
    tx_mode  = 0;
    busy_len = 20;

    // ---- 1: reset state --------------------------------------------------
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_empty",    empty,    1);
    check("rst_full",     full,     0);
    check("rst_count",    count,    0);
    check("rst_overflow", overflow, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_sdata",    sdata,    8'h00);

    // ---- 2: single byte with a 20-cycle busy window ----------------------
    rstn     = 1'b1;
    tx_mode  = 1;
    busy_len = 20;
    @(negedge clk);
    base_cnt = start_cnt;
    wdata    = 8'hA5;
    wr_en    = 1'b1;
    @(negedge clk);                       // push edge E
    wr_en = 1'b0;
    check("one_count_after_push", count,    1);
    check("one_no_start_yet",     tx_start, 0);
    @(negedge clk);                       // edge E+1
    check("one_tx_start", tx_start, 1);
    check("one_sdata",    sdata,    8'hA5);
    check("one_count_0",  count,    0);
    repeat (30) @(negedge clk);
    check("one_single_pulse", start_cnt - base_cnt, 1);
    check("one_empty_end",    empty,    1);
    check("one_sdata_holds",  sdata,    8'hA5);

    // ---- 3: fill to 16 behind a stalled transmitter, then overflow -------
    // A priming byte is taken by the idle FSM first, parking it in
    // S_WAIT_DONE so the next 16 pushes all stay queued.
    tx_mode  = 0;
    busy_man = 1'b1;
    wdata    = 8'hEE;
    wr_en    = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    repeat (3) @(negedge clk);
    check("fill_prime_popped", count, 0);
    cap_q.delete();
    for (int i = 0; i < 16; i++) begin
      wdata = 8'(i);
      wr_en = 1'b1;
      @(negedge clk);
    end
    check("fill_full",     full,     1);
    check("fill_count",    count,    16);
    check("fill_empty",    empty,    0);
    check("fill_no_ovf",   overflow, 0);
    wdata = 8'hFF;
    @(negedge clk);
    wr_en = 1'b0;
    check("ovf_flag",      overflow, 1);
    check("ovf_count",     count,    16);
    busy_man = 1'b0;
    tx_mode  = 1;
    busy_len = 4;
    for (int k = 0; k < 800 && cap_q.size() < 16; k++) @(negedge clk);
    repeat (20) @(negedge clk);
    check("drain_len", cap_q.size(), 16);
    for (int i = 0; i < 16 && i < cap_q.size(); i++) begin
      check($sformatf("drain_byte%0d", i), cap_q[i], i);
    end
    check("drain_empty",   empty,    1);
    check("ovf_sticky",    overflow, 1);

    // ---- 4: push into a full FIFO on the pop edge ------------------------
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    check("rst2_overflow", overflow, 0);
    tx_mode  = 0;
    busy_man = 1'b1;
    wdata    = 8'hEE;
    wr_en    = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    repeat (3) @(negedge clk);
    cap_q.delete();
    for (int i = 0; i < 16; i++) begin
      wdata = 8'h20 + 8'(i);
      wr_en = 1'b1;
      @(negedge clk);
    end
    wr_en = 1'b0;
    check("pp_full_before", count, 16);
    busy_man = 1'b0;                      // FSM returns to S_IDLE next edge
    tx_mode  = 1;
    busy_len = 4;
    @(negedge clk);
    wdata = 8'h55;                        // lands on the pop edge
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    check("pp_count_16",  count,    16);
    check("pp_full",      full,     1);
    check("pp_tx_start",  tx_start, 1);
    check("pp_sdata",     sdata,    8'h20);
    check("pp_no_ovf",    overflow, 0);
    for (int k = 0; k < 800 && cap_q.size() < 17; k++) @(negedge clk);
    repeat (20) @(negedge clk);
    check("pp_len", cap_q.size(), 17);
    if (cap_q.size() == 17) begin
      check("pp_byte0",  cap_q[0],  8'h20);
      check("pp_byte15", cap_q[15], 8'h2F);
      check("pp_last",   cap_q[16], 8'h55);
    end
    check("pp_ovf_end",   overflow, 0);

    // ---- 5: 40 bytes through a serial transmitter, pointers wrap twice ---
    rstn = 1'b0;
    @(negedge clk);
    rstn    = 1'b1;
    tx_mode = 2;
    rx_q.delete();
    exp_q.delete();
    for (int i = 0; i < 40; i++) begin
      for (int k = 0; k < 2000 && full; k++) @(negedge clk);
      v     = 8'(i * 37 + 11);
      exp_q.push_back(v);
      wdata = v;
      wr_en = 1'b1;
      @(negedge clk);
      wr_en = 1'b0;
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end
    for (int k = 0; k < 8000 && rx_q.size() < 40; k++) @(negedge clk);
    repeat (20) @(negedge clk);
    check("ser_len", rx_q.size(), 40);
    for (int i = 0; i < 40 && i < rx_q.size(); i++) begin
      check($sformatf("ser_byte%0d", i), rx_q[i], exp_q[i]);
    end
    check("ser_no_ovf", overflow, 0);
    check("ser_empty",  empty,    1);

    // ---- 6: reset while parked in S_WAIT_DONE with 5 bytes queued -------
    tx_mode  = 0;
    busy_man = 1'b1;
    wdata    = 8'hEE;
    wr_en    = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      wdata = 8'h61 + 8'(i);
      wr_en = 1'b1;
      @(negedge clk);
    end
    wr_en = 1'b0;
    check("abort_queued", count, 5);
    rstn     = 1'b0;
    busy_man = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    check("abort_count", count,    0);
    check("abort_empty", empty,    1);
    check("abort_start", tx_start, 0);
    base_cnt = start_cnt;
    repeat (10) @(negedge clk);
    check("abort_quiet", start_cnt - base_cnt, 0);
    tx_mode  = 1;
    busy_len = 4;
    wdata    = 8'h77;
    wr_en    = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    @(negedge clk);
    check("abort_new_start", tx_start, 1);
    check("abort_new_sdata", sdata,    8'h77);
    repeat (20) @(negedge clk);

    check("no_double_start", dbl_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
